forth_stack_unit: RTL
=====================

# forth_stack_unit

Parametrised Forth stack with a two-register cache (TOS/NOS) in front of a register-array backing store. It supports the Forth stack primitives as single-cycle operations, reports depth, and detects overflow and underflow. It is the common replacement for the separate data-stack and return-stack datapaths, TOP/NEXT registers and their muxes, and is instantiated once per stack in the processor top level.

## Interface
- DATA_WIDTH, 16, entry width in bits
- DEPTH, 16, backing-store entries; total capacity CAP = DEPTH+2
- CNT_WIDTH, $clog2(DEPTH+3), width of depth count
- read_clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- op_valid  in  1  execute op this cycle
- op  in  3  operation code (see Operation)
- din  in  DATA_WIDTH  push / replace data (immediate, ALU result, input register)
- tos  out  DATA_WIDTH  top of stack, registered
- nos  out  DATA_WIDTH  second entry, registered
- depth  out  CNT_WIDTH  live entries, 0..CAP
- empty  out  1  depth==0
- full  out  1  depth==CAP
- overflow  out  1  one-cycle pulse: op suppressed, capacity exceeded
- underflow  out  1  one-cycle pulse: op suppressed, too few entries
- error  out  1  see Configuration

## Operation
- Op codes: 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 REPL, 7 POPREPL.
- Cache rule: entries 1 and 2 live in tos/nos; entries 3..depth live in mem[0..depth-3]; sp = max(depth-2,0) is the next free mem slot.
- PUSH: if depth>=2, mem[sp]<=nos; nos<=tos; tos<=din; depth+1. Requires depth<CAP.
- DUP: as PUSH with tos as data. Requires 1<=depth<CAP.
- OVER: as PUSH with nos as data. Requires 2<=depth<CAP.
- DROP: tos<=nos; nos<=mem[sp-1] if depth>=3, else 0; depth-1. Requires depth>=1.
- SWAP: exchange tos/nos. Requires depth>=2.
- REPL: tos<=din (unary ALU result). Requires depth>=1.
- POPREPL: tos<=din; nos<=mem[sp-1] if depth>=3, else 0; depth-1 (binary ALU result). Requires depth>=2.
- Vacated cache registers are cleared to 0. mem contents above sp are don't-care and are never observable.
- Illegal op: all state is unchanged. A capacity violation asserts overflow; an insufficient-entries violation asserts underflow. DUP/OVER on a full stack is overflow.
- op_valid=0 or NOP: no state change, no flags.

## Timing
- Every op completes in 1 cycle. tos/nos/depth/empty/full reflect the op after the same rising edge.
- overflow/underflow are registered and high for exactly the cycle following the offending edge.
- mem read is combinational at sp-1. mem write is synchronous. There is no read-after-write hazard because each op touches at most one slot.
- Back-to-back ops are allowed every cycle without bubbles.
- Reset: tos=0, nos=0, depth=0, empty=1, full=0, overflow=0, underflow=0, error=0. Reset has priority over op_valid in the same cycle and aborts nothing beyond that cycle.

## Configuration
- STACK_STICKY_ERR_EN defined: error latches high on the first overflow or underflow pulse and stays high until reset. Stack operation continues normally.
- Not defined: error = overflow | underflow (combinational OR of the pulses). No latch register exists.

## Structure
- Shared package forth_stack_pkg: op enum (STK_NOP..STK_POPREPL) and the 3-bit op width constant. The processor control unit and the return-stack instance share this package.
- One sub-module, forth_stack_mem: DEPTH x DATA_WIDTH register array with a synchronous write port and a combinational read port, addressed by sp.
- Top of forth_stack_unit: depth counter, legality check, and the tos/nos next-state mux.

## Test plan
- Reset, then PUSH 0x0011, 0x0022, 0x0033 -> tos=0x0033, nos=0x0022, depth=3, mem[0]=0x0011. DROP x3 -> tos=0, depth=0, empty=1.
- DEPTH=2 (CAP=4): PUSH 1..4 -> full=1. PUSH 5 -> overflow pulse 1 cycle, tos=4, depth=4. DUP also -> overflow.
- Empty stack: DROP -> underflow, depth=0. PUSH 7, SWAP -> underflow, tos=7. POPREPL -> underflow.
- PUSH 3, PUSH 5, OVER -> tos=3, nos=5, depth=3. SWAP -> tos=5, nos=3. POPREPL din=8 -> tos=8, nos=3, depth=2.
- PUSH 9, REPL din=0xFFFF -> tos=0xFFFF, depth=1. op_valid=1 with reset=1 -> all outputs at reset values.
- With STACK_STICKY_ERR_EN: underflow, then 10 valid ops -> error stays 1 until reset. Without the macro: error high for one cycle only.

Source files
------------

// File: rtl/forth_stack_pkg.sv
// Shared Forth stack definitions: op encoding used by the control unit and
// by every stack instance (data stack and return stack).
package forth_stack_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    STK_NOP     = 3'd0,
    STK_PUSH    = 3'd1,
    STK_DROP    = 3'd2,
    STK_DUP     = 3'd3,
    STK_SWAP    = 3'd4,
    STK_OVER    = 3'd5,
    STK_REPL    = 3'd6,
    STK_POPREPL = 3'd7
  } stk_op_e;

endpackage

// File: rtl/forth_stack_mem.sv
// Backing store behind the TOS/NOS cache: DEPTH x DATA_WIDTH register array,
// one synchronous write port and one combinational read port.
module forth_stack_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we && waddr == AW'(i)) mem[i] <= wdata;
    end
  end

  // Decoded read keeps out-of-range addresses harmless (reads as zero).
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/forth_stack_unit.sv
// Forth stack with TOS/NOS register cache over forth_stack_mem.
// Optional macro STACK_STICKY_ERR_EN makes error latch until reset.
module forth_stack_unit
  import forth_stack_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 3)
) (
  input  logic                  read_clock,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [OP_W-1:0]       op,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] tos,
  output logic [DATA_WIDTH-1:0] nos,
  output logic [CNT_WIDTH-1:0]  depth,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  error
);

  localparam logic [CNT_WIDTH-1:0] CAP_C = CNT_WIDTH'(DEPTH + 2);

  stk_op_e               op_e;
  logic                  grows, shrinks, go, unf_c, ovf_c;
  logic                  ge2, ge3, mem_we;
  logic [1:0]            need;
  logic [CNT_WIDTH-1:0]  sp, rd_ptr, cnt_n;
  logic [DATA_WIDTH-1:0] push_data, tos_n, nos_n, mem_rdata;

  assign op_e   = stk_op_e'(op);
  assign ge2    = depth >= CNT_WIDTH'(2);
  assign ge3    = depth >= CNT_WIDTH'(3);
  assign sp     = ge2 ? depth - CNT_WIDTH'(2) : '0;
  assign rd_ptr = sp - CNT_WIDTH'(1);
  assign empty  = depth == '0;
  assign full   = depth == CAP_C;

  // Op classification: minimum entries needed and whether the stack grows.
  always_comb begin
    grows     = 1'b0;
    shrinks   = 1'b0;
    need      = 2'd0;
    push_data = din;
    case (op_e)
      STK_PUSH:    grows = 1'b1;
      STK_DUP:     begin grows = 1'b1; need = 2'd1; push_data = tos; end
      STK_OVER:    begin grows = 1'b1; need = 2'd2; push_data = nos; end
      STK_DROP:    begin shrinks = 1'b1; need = 2'd1; end
      STK_SWAP:    need = 2'd2;
      STK_REPL:    need = 2'd1;
      STK_POPREPL: begin shrinks = 1'b1; need = 2'd2; end
      default:     need = 2'd0;
    endcase
  end

  assign unf_c  = op_valid && (depth < CNT_WIDTH'(need));
  assign ovf_c  = op_valid && !unf_c && grows && full;
  assign go     = op_valid && !unf_c && !ovf_c;
  assign mem_we = go && grows && ge2;

  always_comb begin
    tos_n = tos;
    nos_n = nos;
    cnt_n = depth;
    if (go) begin
      if (grows) begin
        nos_n = tos;
        tos_n = push_data;
        cnt_n = depth + CNT_WIDTH'(1);
      end else if (shrinks) begin
        tos_n = (op_e == STK_POPREPL) ? din : nos;
        nos_n = ge3 ? mem_rdata : '0;
        cnt_n = depth - CNT_WIDTH'(1);
      end else if (op_e == STK_SWAP) begin
        tos_n = nos;
        nos_n = tos;
      end else if (op_e == STK_REPL) begin
        tos_n = din;
      end
    end
  end

  forth_stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (CNT_WIDTH)
  ) u_mem (
    .clk   (read_clock),
    .we    (mem_we),
    .waddr (sp),
    .wdata (nos),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Cache and count update; flags are single-cycle pulses.
  always_ff @(posedge read_clock) begin
    if (reset) begin
      tos       <= '0;
      nos       <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      tos       <= tos_n;
      nos       <= nos_n;
      depth     <= cnt_n;
      overflow  <= ovf_c;
      underflow <= unf_c;
    end
  end

`ifdef STACK_STICKY_ERR_EN
  logic err_q;

  always_ff @(posedge read_clock) begin
    if (reset)               err_q <= 1'b0;
    else if (ovf_c || unf_c) err_q <= 1'b1;
  end

  assign error = err_q;
`else
  assign error = overflow | underflow;
`endif

endmodule
